// File: rtl/dds_sched_pkg.sv
// rtl/dds_sched_pkg.sv - shared types and widths for the DDS parameter scheduler
package dds_sched_pkg;

    // Field widths of the queued command; the top-level width parameters must not exceed these.
    localparam int DDS_TS_W    = 48;
    localparam int DDS_FREQ_W  = 48;
    localparam int DDS_PHASE_W = 14;

    typedef enum logic [1:0] {
        ACC_HOLD = 2'd0,
        ACC_LOAD = 2'd1,
        ACC_ADD  = 2'd2,
        ACC_ZERO = 2'd3
    } accum_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2
    } sched_state_e;

    typedef struct packed {
        logic [DDS_TS_W-1:0]    cmd_time;
        logic [DDS_FREQ_W-1:0]  freq;
        logic [DDS_PHASE_W-1:0] phase;
        logic [DDS_TS_W-1:0]    accum;
        accum_mode_e            mode;
    } dds_cmd_t;

endpackage

// File: rtl/dds_cmd_fifo.sv
// rtl/dds_cmd_fifo.sv - synchronous FIFO of dds_cmd_t with full/empty flags
module dds_cmd_fifo
    import dds_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  dds_cmd_t wr_data,
    output dds_cmd_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    dds_cmd_t        mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/dds_param_scheduler.sv
// rtl/dds_param_scheduler.sv - timed DDS operand scheduler with 48-bit timestamp counter
// Optional LATE_DROP_EN: late commands are discarded instead of applied immediately.
module dds_param_scheduler
    import dds_sched_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 48,
    parameter int FREQ_W     = 48,
    parameter int PHASE_W    = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               counter_clear,
    input  logic               s_cmd_valid,
    output logic               s_cmd_ready,
    input  logic [TS_W-1:0]    s_cmd_time,
    input  logic [FREQ_W-1:0]  s_cmd_freq,
    input  logic [PHASE_W-1:0] s_cmd_phase,
    input  logic [TS_W-1:0]    s_cmd_accum,
    input  logic [1:0]         s_cmd_mode,
    input  logic               late_clear,
    output logic [TS_W-1:0]    timestamp,
    output logic [TS_W-1:0]    time_offset,
    output logic [FREQ_W-1:0]  freq,
    output logic [PHASE_W-1:0] phase,
    output logic [TS_W-1:0]    accum_phase,
    output logic               update_pulse,
    output logic               late_error,
    output logic               busy
);

    sched_state_e        state_q, state_d;
    dds_cmd_t            pend_q, pend_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [TS_W-1:0]     toff_q, toff_d;
    logic [FREQ_W-1:0]   freq_q, freq_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [TS_W-1:0]     accum_q, accum_d;
    logic                update_q, update_d;
    logic                late_q, late_d;
    logic                rdy_en_q, rdy_en_d;

    dds_cmd_t            cmd_in, head;
    logic                fifo_full, fifo_empty, push, pop, apply;
    logic [TS_W-1:0]     p_time, p_accum, diff;
    logic [FREQ_W-1:0]   p_freq;
    logic [PHASE_W-1:0]  p_phase;
    accum_mode_e         p_mode;

    assign s_cmd_ready = rdy_en_q && !fifo_full;
    assign push        = s_cmd_valid && s_cmd_ready;
    assign pop         = (state_q == ST_LOAD);
    assign busy        = !fifo_empty || (state_q != ST_IDLE);

    always_comb begin
        cmd_in          = '0;
        cmd_in.cmd_time = DDS_TS_W'(s_cmd_time);
        cmd_in.freq     = DDS_FREQ_W'(s_cmd_freq);
        cmd_in.phase    = DDS_PHASE_W'(s_cmd_phase);
        cmd_in.accum    = DDS_TS_W'(s_cmd_accum);
        cmd_in.mode     = accum_mode_e'(s_cmd_mode);
    end

    dds_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (cmd_in),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign p_time  = pend_q.cmd_time[TS_W-1:0];
    assign p_freq  = pend_q.freq[FREQ_W-1:0];
    assign p_phase = pend_q.phase[PHASE_W-1:0];
    assign p_accum = pend_q.accum[TS_W-1:0];
    assign p_mode  = pend_q.mode;

    always_comb begin
        ts_d = ts_q;
        if (counter_clear) begin
            ts_d = '0;
        end else if (run) begin
            ts_d = ts_q + TS_W'(1);
        end
    end

    // Compared against the next counter value so the operands land on the same edge as timestamp==cmd_time.
    assign diff = p_time - ts_d;

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        toff_d   = toff_q;
        freq_d   = freq_q;
        phase_d  = phase_q;
        accum_d  = accum_q;
        update_d = 1'b0;
        late_d   = late_q;
        rdy_en_d = 1'b1;
        apply    = 1'b0;

        if (late_clear) begin
            late_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                pend_d  = head;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (diff == '0) begin
                    apply   = 1'b1;
                    state_d = ST_IDLE;
                end else if (diff[TS_W-1]) begin
                    late_d  = 1'b1;
                    state_d = ST_IDLE;
`ifdef LATE_DROP_EN
                    apply   = 1'b0;
`else
                    apply   = 1'b1;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (apply) begin
            toff_d   = p_time;
            freq_d   = p_freq;
            phase_d  = p_phase;
            update_d = 1'b1;
            case (p_mode)
                ACC_HOLD: accum_d = accum_q;
                ACC_LOAD: accum_d = p_accum;
                ACC_ADD:  accum_d = accum_q + p_accum;
                ACC_ZERO: accum_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            ts_q     <= '0;
            toff_q   <= '0;
            freq_q   <= '0;
            phase_q  <= '0;
            accum_q  <= '0;
            update_q <= 1'b0;
            late_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            ts_q     <= ts_d;
            toff_q   <= toff_d;
            freq_q   <= freq_d;
            phase_q  <= phase_d;
            accum_q  <= accum_d;
            update_q <= update_d;
            late_q   <= late_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    assign timestamp    = ts_q;
    assign time_offset  = toff_q;
    assign freq         = freq_q;
    assign phase        = phase_q;
    assign accum_phase  = accum_q;
    assign update_pulse = update_q;
    assign late_error   = late_q;

endmodule

// File: tb/tb_dds_param_scheduler.sv
// tb/tb_dds_param_scheduler.sv - directed self-checking bench for dds_param_scheduler
module tb_dds_param_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        counter_clear = 1'b0;
    logic        s_cmd_valid = 1'b0;
    logic        s_cmd_ready;
    logic [47:0] s_cmd_time = '0;
    logic [47:0] s_cmd_freq = '0;
    logic [13:0] s_cmd_phase = '0;
    logic [47:0] s_cmd_accum = '0;
    logic [1:0]  s_cmd_mode = '0;
    logic        late_clear = 1'b0;
    logic [47:0] timestamp, time_offset, freq, accum_phase;
    logic [13:0] phase;
    logic        update_pulse, late_error, busy;

    // Narrow-counter instance used to reach the timestamp wrap quickly.
    logic        run_w = 1'b0;
    logic        clear_w = 1'b0;
    logic        valid_w = 1'b0;
    logic        ready_w;
    logic [7:0]  time_w = '0;
    logic [7:0]  accum_in_w = '0;
    logic [7:0]  ts_w, toff_w, accum_w;
    logic [47:0] freq_w;
    logic [13:0] phase_w;
    logic        upd_w, late_w, busy_w;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    dds_param_scheduler dut (
        .clk(clk), .reset(reset), .run(run), .counter_clear(counter_clear),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_time(s_cmd_time),
        .s_cmd_freq(s_cmd_freq), .s_cmd_phase(s_cmd_phase), .s_cmd_accum(s_cmd_accum),
        .s_cmd_mode(s_cmd_mode), .late_clear(late_clear), .timestamp(timestamp),
        .time_offset(time_offset), .freq(freq), .phase(phase), .accum_phase(accum_phase),
        .update_pulse(update_pulse), .late_error(late_error), .busy(busy)
    );

    dds_param_scheduler #(.TS_W(8)) dut_w (
        .clk(clk), .reset(reset), .run(run_w), .counter_clear(clear_w),
        .s_cmd_valid(valid_w), .s_cmd_ready(ready_w), .s_cmd_time(time_w),
        .s_cmd_freq(48'h7), .s_cmd_phase(14'h3), .s_cmd_accum(accum_in_w),
        .s_cmd_mode(2'b01), .late_clear(1'b0), .timestamp(ts_w),
        .time_offset(toff_w), .freq(freq_w), .phase(phase_w), .accum_phase(accum_w),
        .update_pulse(upd_w), .late_error(late_w), .busy(busy_w)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic [47:0] t, input logic [47:0] f, input logic [13:0] p,
                            input logic [47:0] a, input logic [1:0] m);
        int n = 0;
        @(negedge clk);
        s_cmd_valid = 1'b1;
        s_cmd_time  = t;
        s_cmd_freq  = f;
        s_cmd_phase = p;
        s_cmd_accum = a;
        s_cmd_mode  = m;
        while (!s_cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!s_cmd_ready) chk("push_timeout", 64'(s_cmd_ready), 64'd1);
        @(posedge clk);
        #1;
        s_cmd_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (update_pulse) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_counter();
        @(negedge clk);
        counter_clear = 1'b1;
        @(negedge clk);
        counter_clear = 1'b0;
    endtask

    initial begin
        bit got;
        int cnt;

        repeat (3) @(negedge clk);
        chk("rst_ts", 64'(timestamp), 64'd0);
        chk("rst_toff", 64'(time_offset), 64'd0);
        chk("rst_accum", 64'(accum_phase), 64'd0);
        chk("rst_pulse", 64'(update_pulse), 64'd0);
        chk("rst_ready", 64'(s_cmd_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        run = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(s_cmd_ready), 64'd1);

        // Basic on-time apply.
        push_cmd(48'd100, 48'h1000, 14'h155, 48'h42, 2'b01);
        wait_pulse(200, got);
        chk("t1_pulse", 64'(got), 64'd1);
        chk("t1_ts", 64'(timestamp), 64'd100);
        chk("t1_toff", 64'(time_offset), 64'd100);
        chk("t1_freq", 64'(freq), 64'h1000);
        chk("t1_phase", 64'(phase), 64'h155);
        chk("t1_accum", 64'(accum_phase), 64'h42);
        chk("t1_late", 64'(late_error), 64'd0);
        @(negedge clk);
        chk("t1_pulse_width", 64'(update_pulse), 64'd0);

        // Late command.
        clear_counter();
        cnt = 0;
        while (timestamp != 48'd200 && cnt < 400) begin
            @(negedge clk);
            cnt++;
        end
        push_cmd(48'd150, 48'h2222, 14'h0AA, 48'h0, 2'b00);
`ifdef LATE_DROP_EN
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (update_pulse) cnt++;
        end
        chk("late_drop_pulses", 64'(cnt), 64'd0);
        chk("late_drop_toff", 64'(time_offset), 64'd100);
        chk("late_drop_freq", 64'(freq), 64'h1000);
`else
        wait_pulse(10, got);
        chk("late_pulse", 64'(got), 64'd1);
        chk("late_toff", 64'(time_offset), 64'd150);
        chk("late_freq", 64'(freq), 64'h2222);
        chk("late_accum_hold", 64'(accum_phase), 64'h42);
`endif
        chk("late_flag", 64'(late_error), 64'd1);
        @(negedge clk);
        late_clear = 1'b1;
        @(negedge clk);
        late_clear = 1'b0;
        chk("late_cleared", 64'(late_error), 64'd0);

        // Accumulator modes.
        clear_counter();
        push_cmd(48'd30, 48'h1, 14'h1, 48'hFFFF_FFFF_FFFF, 2'b01);
        wait_pulse(100, got);
        chk("acc_load", 64'(accum_phase), 64'hFFFF_FFFF_FFFF);
        push_cmd(48'd60, 48'h2, 14'h2, 48'h2, 2'b10);
        wait_pulse(100, got);
        chk("acc_add_wrap", 64'(accum_phase), 64'h1);
        chk("acc_add_ts", 64'(timestamp), 64'd60);
        push_cmd(48'd90, 48'h3, 14'h3, 48'h999, 2'b00);
        wait_pulse(100, got);
        chk("acc_hold", 64'(accum_phase), 64'h1);
        chk("acc_hold_freq", 64'(freq), 64'h3);
        push_cmd(48'd120, 48'h4, 14'h4, 48'h999, 2'b11);
        wait_pulse(100, got);
        chk("acc_zero", 64'(accum_phase), 64'h0);

        // Counter control and apply with run=0.
        @(negedge clk);
        run = 1'b0;
        counter_clear = 1'b1;
        @(negedge clk);
        counter_clear = 1'b0;
        chk("cnt_clear", 64'(timestamp), 64'd0);
        run = 1'b1;
        repeat (7) @(negedge clk);
        run = 1'b0;
        chk("cnt_run7", 64'(timestamp), 64'd7);
        repeat (3) @(negedge clk);
        chk("cnt_hold", 64'(timestamp), 64'd7);
        push_cmd(48'd7, 48'h77, 14'h7, 48'h0, 2'b00);
        wait_pulse(20, got);
        chk("stopped_pulse", 64'(got), 64'd1);
        chk("stopped_toff", 64'(time_offset), 64'd7);
        chk("stopped_ts", 64'(timestamp), 64'd7);
        run = 1'b1;

        // Fill the queue: pending slot plus FIFO_DEPTH entries.
        clear_counter();
        for (int i = 0; i < 9; i++) begin
            push_cmd(48'(50 + 10 * i), 48'(i + 1), 14'(i), 48'h0, 2'b00);
        end
        chk("full_ready", 64'(s_cmd_ready), 64'd0);
        chk("full_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 9; i++) begin
            wait_pulse(200, got);
            chk("order_pulse", 64'(got), 64'd1);
            chk("order_toff", 64'(time_offset), 64'(50 + 10 * i));
            chk("order_ts", 64'(timestamp), 64'(50 + 10 * i));
            chk("order_freq", 64'(freq), 64'(i + 1));
        end
        chk("busy_fall", 64'(busy), 64'd0);
        chk("order_late", 64'(late_error), 64'd0);

        // Reset while waiting with three queued behind the pending command.
        clear_counter();
        for (int i = 0; i < 4; i++) begin
            push_cmd(48'(300 + 10 * i), 48'h5, 14'h5, 48'h5, 2'b01);
        end
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_toff", 64'(time_offset), 64'd0);
        chk("mid_rst_freq", 64'(freq), 64'd0);
        chk("mid_rst_phase", 64'(phase), 64'd0);
        chk("mid_rst_ts", 64'(timestamp), 64'd0);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (update_pulse) cnt++;
        end
        chk("post_rst_pulses", 64'(cnt), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_toff", 64'(time_offset), 64'd0);

        // Timestamp wrap on the 8-bit instance.
        @(negedge clk);
        run_w = 1'b1;
        clear_w = 1'b1;
        @(negedge clk);
        clear_w = 1'b0;
        cnt = 0;
        while (ts_w != 8'd249 && cnt < 300) begin
            @(negedge clk);
            cnt++;
        end
        valid_w = 1'b1;
        time_w = 8'd2;
        accum_in_w = 8'h5;
        @(posedge clk);
        #1;
        valid_w = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (upd_w) begin
                got = 1'b1;
                break;
            end
        end
        chk("wrap_pulse", 64'(got), 64'd1);
        chk("wrap_ts", 64'(ts_w), 64'd2);
        chk("wrap_toff", 64'(toff_w), 64'd2);
        chk("wrap_accum", 64'(accum_w), 64'h5);
        chk("wrap_late", 64'(late_w), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dds_param_scheduler.md
Name: dds_param_scheduler

Overview:
- Timed parameter stage directly upstream of the DDS phase MAC. Buffers timestamped DDS commands (frequency, phase offset, accumulated-phase update) and owns the free-running 48-bit timestamp counter.
- Applies each command on the exact cycle its timestamp is reached, driving the MAC's time-offset, frequency, phase, timestamp and accumulated-phase operands coherently.

Parameters:
- FIFO_DEPTH, 8, command queue entries (power of 2, ≥2)
- TS_W, 48, timestamp/offset/accum width
- FREQ_W, 48, frequency word width
- PHASE_W, 14, phase-offset width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run  in  1  timestamp counter enable
- counter_clear  in  1  zero the timestamp counter (priority over run)
- s_cmd_valid  in  1  command valid
- s_cmd_ready  out  1  queue not full
- s_cmd_time  in  TS_W  apply timestamp
- s_cmd_freq  in  FREQ_W  frequency word
- s_cmd_phase  in  PHASE_W  phase offset
- s_cmd_accum  in  TS_W  accumulated-phase operand
- s_cmd_mode  in  2  accum update mode
- late_clear  in  1  clear sticky late flag
- timestamp  out  TS_W  current counter value (MAC timestamp operand)
- time_offset  out  TS_W  MAC time-offset operand
- freq  out  FREQ_W  MAC frequency operand
- phase  out  PHASE_W  MAC phase operand
- accum_phase  out  TS_W  MAC accumulated-phase operand
- update_pulse  out  1  one-cycle pulse on the cycle new operands appear
- late_error  out  1  sticky, a command was late
- busy  out  1  queue or pending slot non-empty

Behaviour:
- Reset: all outputs 0; s_cmd_ready=1 on the cycle after reset deasserts; queue and pending slot emptied. Reset mid-wait discards all commands.
- Counter: next_ts = counter_clear ? 0 : run ? ts+1 : ts. Wraps modulo 2^TS_W.
- Queue: push when s_cmd_valid && s_cmd_ready. s_cmd_ready = !full. Simultaneous push and pop at full is not allowed (ready is already low). Push and pop at non-full happen in the same cycle.
- FSM IDLE -> LOAD -> WAIT -> IDLE:
  - IDLE: queue non-empty -> LOAD.
  - LOAD: pop the head into the pending slot (1 cycle) -> WAIT.
  - WAIT: diff = s_cmd_time_pending - next_ts, as signed TS_W.
    - diff==0: apply on this edge, so the operands and timestamp==cmd_time are registered together; then IDLE.
    - diff<0: late.
    - diff>0: stay in WAIT.
- Apply:
  - time_offset<=cmd_time; freq<=cmd_freq; phase<=cmd_phase.
  - accum_phase by mode: 00 hold; 01 load cmd_accum; 10 accum_phase+cmd_accum mod 2^TS_W; 11 zero.
  - update_pulse=1 for one cycle.
- Back-to-back commands with consecutive timestamps cannot both apply (LOAD costs one cycle). The second is flagged late.
- run=0 with next_ts==cmd_time applies immediately. With diff>0 it waits indefinitely.
- counter_clear while WAIT re-evaluates diff against 0 on the next cycle.
- late_error: set on a late detection, cleared by late_clear. Set has priority when both occur in the same cycle.
- busy = !empty || state!=IDLE.

Optional Feature:
- LATE_DROP_EN defined: a late command is discarded (no operand change, no update_pulse), late_error set, FSM -> IDLE.
- Undefined: a late command is applied immediately (time_offset<=cmd_time as given), update_pulse asserted, late_error set.

Decomposition:
- Package dds_sched_pkg: packed struct dds_cmd_t {time, freq, phase, accum, mode}; enum accum_mode_e {ACC_HOLD, ACC_LOAD, ACC_ADD, ACC_ZERO}; state enum; width localparams.
- Sub-module dds_cmd_fifo: synchronous FIFO of dds_cmd_t with full/empty flags.

Test Plan:
- Reset, run=1, push {time=100, freq=0x1000, phase=0x155, mode=LOAD, accum=0x42} -> update_pulse on the cycle timestamp==100; time_offset=100, freq=0x1000, phase=0x155, accum_phase=0x42.
- At ts=200 push time=150 -> late_error=1. With LATE_DROP_EN outputs unchanged; without it operands update with time_offset=150. late_clear -> 0.
- Mode ADD with accum_phase=0xFFFF_FFFF_FFFF and cmd_accum=2 -> accum_phase=1 (wrap). Mode ZERO -> 0. Mode HOLD -> unchanged.
- Counter set near 2^48-3, command time=2 -> applied after wrap, exactly when timestamp==2.
- Push FIFO_DEPTH+1 commands with future times while waiting -> s_cmd_ready low at full; all applied in timestamp order; busy falls after the last.
- Reset asserted during WAIT with 3 queued -> no update_pulse afterwards, outputs 0, busy=0.
